// File: rtl/decode_regfile_if.sv
// rtl/decode_regfile_if.sv - decode/regfile bundle: fetch/execute/memory inputs, decoded IDs, read data, live registers.
interface decode_regfile_if;
  logic        en;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        Cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi;
  logic [63:0] r8, r9, r10, r11, r12, r13, r14;

  modport master (
    output en, icode, rA, rB, Cnd, valE, valM,
    input  srcA, srcB, dstE, dstM, valA, valB,
    input  rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
    input  r8, r9, r10, r11, r12, r13, r14
  );

  modport slave (
    input  en, icode, rA, rB, Cnd, valE, valM,
    output srcA, srcB, dstE, dstM, valA, valB,
    output rax, rcx, rdx, rbx, rsp, rbp, rsi, rdi,
    output r8, r9, r10, r11, r12, r13, r14
  );
endinterface

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - Y86-64 SEQ register file with decode-side source/destination selection.
// Reads are combinational from pre-edge state; valE/valM commit on the rising edge.
module decode_regfile #(
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  decode_regfile_if.slave bus
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  logic [3:0]  src_a, src_b, dst_e, dst_m;

  // Only icode steers decode, so X on rA/rB cannot leak into an unused selector.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.icode)
      4'h2: begin
        src_a = bus.rA;
        dst_e = bus.Cnd ? bus.rB : RNONE;
      end
      4'h3: dst_e = bus.rB;
      4'h4: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      4'h5: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      4'h6: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      4'h8: begin
        src_b = RSP;
        dst_e = RSP;
      end
      4'h9, 4'hB: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = (bus.icode == 4'hB) ? bus.rA : RNONE;
      end
      4'hA: begin
        src_a = bus.rA;
        src_b = RSP;
        dst_e = RSP;
      end
      default: ;
    endcase
  end

  assign bus.srcA = src_a;
  assign bus.srcB = src_b;
  assign bus.dstE = dst_e;
  assign bus.dstM = dst_m;

  assign bus.valA = (src_a == RNONE) ? 64'd0 : regs_q[src_a];
  assign bus.valB = (src_b == RNONE) ? 64'd0 : regs_q[src_b];

  // M write is applied last so popq %rsp lands valM in rsp.
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.en) begin
      if (dst_e != RNONE) regs_d[dst_e] = bus.valE;
      if (dst_m != RNONE) regs_d[dst_m] = bus.valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : 64'd0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.rax = regs_q[0];
  assign bus.rcx = regs_q[1];
  assign bus.rdx = regs_q[2];
  assign bus.rbx = regs_q[3];
  assign bus.rsp = regs_q[4];
  assign bus.rbp = regs_q[5];
  assign bus.rsi = regs_q[6];
  assign bus.rdi = regs_q[7];
  assign bus.r8  = regs_q[8];
  assign bus.r9  = regs_q[9];
  assign bus.r10 = regs_q[10];
  assign bus.r11 = regs_q[11];
  assign bus.r12 = regs_q[12];
  assign bus.r13 = regs_q[13];
  assign bus.r14 = regs_q[14];

endmodule
